// File: rtl/operand_entry_stack.sv
// Signed BCD operand entry register feeding a small LIFO of committed operands.
// Optional build macro OPERAND_BCD_CHECK_EN rejects non-decimal digit nibbles.
module operand_entry_stack #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                  Clock,
  input  logic                  reset,
  input  logic [1:0]            stateEncoder,
  input  logic                  digit_valid,
  input  logic [3:0]            digit_in,
  input  logic                  sign_toggle,
  input  logic                  clear_entry,
  input  logic                  push,
  input  logic                  pop,
  output logic [4*DIGITS:0]     entry,
  output logic [3:0]            entry_count,
  output logic [4*DIGITS:0]     top,
  output logic [4*DIGITS:0]     second,
  output logic [3:0]            stack_count,
  output logic                  full,
  output logic                  empty,
  output logic                  error
);

  localparam int unsigned W  = 4 * DIGITS + 1;
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_stack [DEPTH];
  logic [3:0]    r_count;
  logic [W-1:0]  r_entry;
  logic [3:0]    r_entry_count;
  logic          r_error;

  logic          w_full, w_empty;
  logic          w_do_push, w_replace, w_do_pop, w_edit, w_fault;
  logic          w_bcd_ok, w_digit_ok;
  logic [AW-1:0] w_top_idx, w_second_idx, w_wr_idx;
  logic [W-1:0]  w_entry_d;
  logic [3:0]    w_entry_count_d;
  logic [W-2:0]  w_mag;

  assign w_full       = (r_count == 4'(DEPTH));
  assign w_empty      = (r_count == 4'd0);
  assign w_top_idx    = AW'(r_count - 4'd1);
  assign w_second_idx = AW'(r_count - 4'd2);

  // push+pop on a non-empty stack overwrites the top instead of growing it
  assign w_replace = push && pop && !w_empty;
  assign w_do_push = w_replace || (push && !w_full);
  assign w_do_pop  = pop && !push && !w_empty;
  assign w_wr_idx  = w_replace ? w_top_idx : AW'(r_count);

  // A successful commit clears the entry, so edits that cycle are moot
  assign w_edit = (stateEncoder == 2'b01) && !w_do_push;

`ifdef OPERAND_BCD_CHECK_EN
  assign w_bcd_ok = (digit_in <= 4'd9);
`else
  assign w_bcd_ok = 1'b1;
`endif

  assign w_digit_ok = digit_valid && w_bcd_ok && (r_entry_count < 4'(DIGITS));

  always_comb begin
    w_fault = 1'b0;
    if (push && !pop && w_full) w_fault = 1'b1;
    if (pop && !push && w_empty) w_fault = 1'b1;
    if (w_edit && !clear_entry && digit_valid && !w_digit_ok) w_fault = 1'b1;
  end

  always_comb begin
    w_entry_d       = r_entry;
    w_entry_count_d = r_entry_count;
    w_mag           = r_entry[W-2:0];
    if (clear_entry) begin
      w_entry_d       = '0;
      w_entry_count_d = 4'd0;
    end else begin
      if (w_digit_ok) begin
        w_mag                = w_mag << 4;
        w_mag[3:0]           = digit_in;
        w_entry_d[W-2:0]     = w_mag;
        w_entry_count_d      = r_entry_count + 4'd1;
      end
      if (sign_toggle) w_entry_d[W-1] = ~r_entry[W-1];
    end
  end

  // Storage is left uninitialised on reset; reads are masked by r_count
  always_ff @(posedge Clock) begin
    if (!reset && w_do_push) r_stack[w_wr_idx] <= r_entry;
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      r_count       <= 4'd0;
      r_entry       <= '0;
      r_entry_count <= 4'd0;
      r_error       <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_entry       <= '0;
        r_entry_count <= 4'd0;
        if (!w_replace) r_count <= r_count + 4'd1;
      end else begin
        if (w_do_pop) r_count <= r_count - 4'd1;
        if (w_edit) begin
          r_entry       <= w_entry_d;
          r_entry_count <= w_entry_count_d;
        end
      end
      if (w_fault) begin
        r_error <= 1'b1;
      end else if (w_edit && clear_entry) begin
        r_error <= 1'b0;
      end
    end
  end

  assign entry       = r_entry;
  assign entry_count = r_entry_count;
  assign stack_count = r_count;
  assign full        = w_full;
  assign empty       = w_empty;
  assign error       = r_error;
  assign top         = w_empty ? '0 : r_stack[w_top_idx];
  assign second      = (r_count < 4'd2) ? '0 : r_stack[w_second_idx];

endmodule
